// File: rtl/mem_access_seq.sv
// Multicycle data-memory load/store sequencer; sub-word stores are read-modify-write on the low bits.
// Latency: load done at T+3, SW at T+2, SH/SB at T+4, error at T+1; start is ignored while busy.
module mem_access_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mdr_load,
  output logic [1:0]  o_ls_ctrl,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [15:0] r_sdata;
  logic [31:0] r_wdata;
  logic [1:0]  r_ls;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_accept;

  // op[1:0] encodes access size (00 word, 01 half, 10 byte); op[2] marks a store.
  assign w_illegal = (i_op[1:0] == 2'b11);
  always_comb begin
    w_misaligned = 1'b0;
    case (i_op[1:0])
      2'b00:   w_misaligned = (i_addr[1:0] != 2'b00);
      2'b01:   w_misaligned = i_addr[0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && i_start;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_mem_wr   = 1'b0;
    o_mdr_load = 1'b0;
    o_done     = 1'b0;
    o_err      = 1'b0;
    o_busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (w_illegal || w_misaligned) w_next = S_ERR;
          else if (i_op == 3'b100)       w_next = S_WRITE;
          else                           w_next = S_READ;
        end
      end
      S_READ: w_next = S_WAIT;
      S_WAIT: begin
        if (!r_op[2]) begin
          o_mdr_load = 1'b1;
          w_next     = S_DONE;
        end else begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_mem_wr = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        o_done = 1'b1;
        o_err  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op    <= 3'b000;
      r_addr  <= 32'd0;
      r_sdata <= 16'd0;
      r_wdata <= 32'd0;
      r_ls    <= 2'b00;
    end else if (w_accept) begin
      r_op    <= i_op;
      r_addr  <= i_addr;
      r_sdata <= i_store_data[15:0];
      if (w_next == S_WRITE) r_wdata <= i_store_data;
      case (i_op)
        3'b001:  r_ls <= 2'b10;
        3'b010:  r_ls <= 2'b01;
        default: r_ls <= 2'b00;
      endcase
    end else if (r_state == S_WAIT && r_op[2]) begin
      // Merge new low half/byte into the word just read back.
      if (r_op[1:0] == 2'b01) r_wdata <= {i_mem_rdata[31:16], r_sdata[15:0]};
      else                    r_wdata <= {i_mem_rdata[31:8], r_sdata[7:0]};
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_ls_ctrl   = r_ls;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: table of transactions with a memory model, scoreboard queue and reset corner cases.
module tb_mem_access_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mdr_load;
  logic [1:0]  ls_ctrl;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_access_seq dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_op         (op),
    .i_addr       (addr),
    .i_store_data (store_data),
    .i_mem_rdata  (mem_rdata),
    .o_mem_addr   (mem_addr),
    .o_mem_wr     (mem_wr),
    .o_mem_wdata  (mem_wdata),
    .o_mdr_load   (mdr_load),
    .o_ls_ctrl    (ls_ctrl),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model covering 0x00-0xFF, preloaded while reset is held.
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hA1B2C3D4;
      mem[8]  <= 32'h11223344;
      mem[17] <= 32'hAABBCCDD;
    end else if (mem_wr) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    bit          poke;
    logic [1:0]  ls;
    int          mdr;
    int          wr;
    logic [31:0] wdata;
    int          dn;
    logic        er;
  } vec_t;

  vec_t tbl [9];
  vec_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Caller is just past a negedge; start is driven here and the txn runs to the IDLE cycle after done.
  task automatic run_txn(input vec_t v);
    int k, got_mdr, got_wr, got_dn, ovl, busy_bad;
    logic        got_er;
    logic [31:0] wd;
    logic [1:0]  lsd;
    vec_t        e;
    sb.push_back(v);
    start = 1'b1; op = v.op; addr = v.addr; store_data = v.sdata;
    k = 0; got_mdr = 0; got_wr = 0; got_dn = 0; ovl = 0; busy_bad = 0;
    got_er = 1'b0; wd = 32'h0; lsd = 2'b00;
    while (got_dn == 0 && k < 10) begin
      @(negedge clk);
      k++;
      if (mdr_load && got_mdr == 0) got_mdr = k;
      if (mem_wr) begin
        if (got_wr == 0) got_wr = k;
        wd = mem_wdata;
      end
      if (mdr_load && mem_wr) ovl = 1;
      if (!busy) busy_bad = 1;
      if (done) begin
        got_dn = k; got_er = err; lsd = ls_ctrl;
      end
      if (k == 1) begin
        start = v.poke;
        if (v.poke) begin op = 3'b100; addr = 32'h40; store_data = 32'hFFFF_FFFF; end
      end
      if (k == 2) start = 1'b0;
    end
    if (got_dn == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", v.name);
    end else begin
      e = sb.pop_front();
      chk({e.name, "_done_cyc"}, got_dn, e.dn);
      chk({e.name, "_err"}, {31'd0, got_er}, {31'd0, e.er});
      chk({e.name, "_mdr_cyc"}, got_mdr, e.mdr);
      chk({e.name, "_wr_cyc"}, got_wr, e.wr);
      if (e.wr != 0) chk({e.name, "_wdata"}, wd, e.wdata);
      chk({e.name, "_ls_ctrl"}, {30'd0, lsd}, {30'd0, e.ls});
      chk({e.name, "_wr_mdr_overlap"}, ovl, 0);
      chk({e.name, "_busy_during"}, busy_bad, 0);
    end
    @(negedge clk);
    chk({v.name, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({v.name, "_done_single"}, {31'd0, done}, 32'd0);
    if (v.poke) begin
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        chk({v.name, "_no_extra_done"}, {31'd0, done | mem_wr}, 32'd0);
      end
      chk({v.name, "_ls_hold"}, {30'd0, ls_ctrl}, {30'd0, v.ls});
    end
  endtask

  initial begin
    //          name      op      addr          sdata         poke ls     mdr wr wdata         dn er
    tbl[0] = '{"lw",     3'b000, 32'h10, 32'h0,        1'b0, 2'b00, 2, 0, 32'h0,        3, 1'b0};
    tbl[1] = '{"lb",     3'b010, 32'h21, 32'h0,        1'b1, 2'b01, 2, 0, 32'h0,        3, 1'b0};
    tbl[2] = '{"lh",     3'b001, 32'h22, 32'h0,        1'b0, 2'b10, 2, 0, 32'h0,        3, 1'b0};
    tbl[3] = '{"lw_mis", 3'b000, 32'h42, 32'h0,        1'b0, 2'b00, 0, 0, 32'h0,        1, 1'b1};
    tbl[4] = '{"sw",     3'b100, 32'h40, 32'hDEADBEEF, 1'b0, 2'b00, 0, 1, 32'hDEADBEEF, 2, 1'b0};
    tbl[5] = '{"sh",     3'b101, 32'h44, 32'h00001234, 1'b0, 2'b00, 0, 3, 32'hAABB1234, 4, 1'b0};
    tbl[6] = '{"sb",     3'b110, 32'h47, 32'h00000077, 1'b0, 2'b00, 0, 3, 32'hAABB1277, 4, 1'b0};
    tbl[7] = '{"sh_mis", 3'b101, 32'h45, 32'h0000FFFF, 1'b0, 2'b00, 0, 0, 32'h0,        1, 1'b1};
    tbl[8] = '{"op011",  3'b011, 32'h10, 32'h0,        1'b0, 2'b00, 0, 0, 32'h0,        1, 1'b1};

    reset = 1'b1; start = 1'b0; op = 3'b000; addr = 32'h0; store_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mdr_load", {31'd0, mdr_load}, 32'd0);
    chk("rst_ls_ctrl", {30'd0, ls_ctrl}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Asynchronous reset in the middle of an SW write cycle.
    start = 1'b1; op = 3'b100; addr = 32'h48; store_data = 32'h55AA55AA;
    @(posedge clk);
    #1 start = 1'b0;
    chk("pre_rst_mem_wr", {31'd0, mem_wr}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midwr_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("midwr_busy", {31'd0, busy}, 32'd0);
    chk("midwr_mem_wdata", mem_wdata, 32'h0);
    chk("midwr_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
